prio_arbiter8: RTL and testbench

Eight-requester bus arbiter that shares one resource, such as a datapath or bus port. The arbiter grants one requester at a time, giving priority to the highest index, and holds the grant until the requester releases it or the hold limit expires. A timed-out requester is masked so that lower indices cannot be starved. Grants are registered and are issued both one-hot and as a 3-bit binary code with a valid flag.

---
 rtl/arb_pkg.sv | 14 +
 rtl/prio_enc8.sv | 19 +
 rtl/prio_arbiter8.sv | 127 ++++++++++++
 tb/tb_prio_arbiter8.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-requester priority arbiter.
//   arb_state_t : arbiter FSM states
//   NUM_REQ     : number of requesters
//   CODE_W      : width of the binary grant index
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 highest-index priority encoder.
//   in   : request vector
//   code : index of the highest set bit (0 when in==0)
//   zero : 1 when no bit of in is set
module prio_enc8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] in,
  output logic [CODE_W-1:0]  code,
  output logic               zero
);
  always_comb begin
    code = '0;
    // Ascending scan: the last set bit seen is the highest index.
    for (int i = 0; i < NUM_REQ; i++)
      if (in[i]) code = CODE_W'(i);
    zero = ~|in;
  end
endmodule

// File: rtl/prio_arbiter8.sv
// Eight-requester arbiter, highest index wins, grant held until release or
// hold-limit timeout. A timed-out owner is masked until it drops its request
// or until only masked requesters remain.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request vector
//   gnt       : registered one-hot grant
//   gnt_code  : binary index of the grant (0 when not valid)
//   gnt_valid : any grant active
//   no_req    : req was all-zero in the previous cycle
//   mask      : starvation mask (debug)
module prio_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [CODE_W-1:0]  gnt_code,
  output logic               gnt_valid,
  output logic               no_req,
  output logic [NUM_REQ-1:0] mask
);
  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CODE_W-1:0]  gnt_code_q, gnt_code_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               no_req_q, no_req_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0] elig;
  logic [CODE_W-1:0]  win;
  logic               elig_zero;

  assign elig = req & ~mask_q;

  prio_enc8 u_enc (
    .in   (elig),
    .code (win),
    .zero (elig_zero)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_code_d  = gnt_code_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    // A requester that lets go is forgiven.
    mask_d      = mask_q & req;
    no_req_d    = (req == '0);

    case (state_q)
      IDLE: begin
        if (!elig_zero) begin
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          gnt_code_d  = win;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = CNT_W'(1);
          state_d     = GRANT;
        end else if (req != '0) begin
          // Only masked requesters left: drop the mask, arbitrate next cycle.
          mask_d = '0;
        end
      end

      GRANT: begin
        if (!req[gnt_code_q]) begin
          gnt_d       = '0;
          gnt_code_d  = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          state_d     = RELEASE;
        end else if (MAX_HOLD != 0 && hold_cnt_q == CNT_W'(MAX_HOLD)) begin
          mask_d[gnt_code_q] = 1'b1;
          gnt_d       = '0;
          gnt_code_d  = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          state_d     = RELEASE;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      RELEASE: state_d = IDLE;  // bus turnaround cycle

      default: begin
        gnt_d       = '0;
        gnt_code_d  = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_code_q  <= '0;
      gnt_valid_q <= 1'b0;
      no_req_q    <= 1'b1;
      mask_q      <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_code_q  <= gnt_code_d;
      gnt_valid_q <= gnt_valid_d;
      no_req_q    <= no_req_d;
      mask_q      <= mask_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_code  = gnt_code_q;
  assign gnt_valid = gnt_valid_q;
  assign no_req    = no_req_q;
  assign mask      = mask_q;
endmodule

// File: tb/tb_prio_arbiter8.sv
// Directed bench for prio_arbiter8: one instance with MAX_HOLD=16, one with
// MAX_HOLD=4 for the mask self-clear sequence.
module tb_prio_arbiter8;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req_a = '0, req_b = '0;
  logic [7:0] gnt_a, gnt_b, mask_a, mask_b;
  logic [2:0] code_a, code_b;
  logic       vld_a, vld_b, nrq_a, nrq_b;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  prio_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_code(code_a),
    .gnt_valid(vld_a), .no_req(nrq_a), .mask(mask_a)
  );

  prio_arbiter8 #(.MAX_HOLD(4), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_code(code_b),
    .gnt_valid(vld_b), .no_req(nrq_b), .mask(mask_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] c,
                       input logic [7:0] m);
    chk({tag, ".gnt"},   32'(gnt_a),  32'(g));
    chk({tag, ".code"},  32'(code_a), 32'(c));
    chk({tag, ".valid"}, 32'(vld_a),  32'(g != 8'h00));
    chk({tag, ".mask"},  32'(mask_a), 32'(m));
  endtask

  initial begin
    // 1. reset then idle
    #2 rst = 1'b1;
    #1;
    chk_a("rst", 8'h00, 3'd0, 8'h00);
    chk("rst.no_req", 32'(nrq_a), 32'd1);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a("idle", 8'h00, 3'd0, 8'h00);
      chk("idle.no_req", 32'(nrq_a), 32'd1);
    end

    // 2. single request, 4 cycles of grant, then release + idle
    req_a = 8'h08;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_a("single", 8'h08, 3'd3, 8'h00);
      chk("single.no_req", 32'(nrq_a), 32'd0);
    end
    req_a = 8'h00;
    step(); chk_a("single.rel", 8'h00, 3'd0, 8'h00);
    chk("single.rel.no_req", 32'(nrq_a), 32'd1);
    step(); chk_a("single.idle", 8'h00, 3'd0, 8'h00);

    // 3. simultaneous requests, timeout after 16, lower index served next
    req_a = 8'h25;
    for (int i = 0; i < 16; i++) begin
      step(); chk_a("simul.hold", 8'h20, 3'd5, 8'h00);
    end
    step(); chk_a("simul.to", 8'h00, 3'd0, 8'h20);
    step(); chk_a("simul.idle", 8'h00, 3'd0, 8'h20);
    step(); chk_a("simul.next", 8'h04, 3'd2, 8'h20);
    req_a = 8'h00;
    step(); chk_a("simul.drop", 8'h00, 3'd0, 8'h00);
    step();

    // 4. non-preemption
    req_a = 8'h02;
    step(); chk_a("npre.g1", 8'h02, 3'd1, 8'h00);
    req_a = 8'h82;
    for (int i = 0; i < 3; i++) begin
      step(); chk_a("npre.hold", 8'h02, 3'd1, 8'h00);
    end
    req_a = 8'h80;
    step(); chk_a("npre.rel", 8'h00, 3'd0, 8'h00);
    step(); chk_a("npre.idle", 8'h00, 3'd0, 8'h00);
    step(); chk_a("npre.g7", 8'h80, 3'd7, 8'h00);
    req_a = 8'h00;
    step(); step();

    // 5. mask self-clear with MAX_HOLD=4, three identical tenures
    req_b = 8'h40;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) begin
        step();
        chk("mself.gnt",  32'(gnt_b),  32'h40);
        chk("mself.code", 32'(code_b), 32'd6);
        chk("mself.vld",  32'(vld_b),  32'd1);
      end
      step();
      chk("mself.to.gnt",  32'(gnt_b),  32'h00);
      chk("mself.to.mask", 32'(mask_b), 32'h40);
      step();
      chk("mself.idle.gnt",  32'(gnt_b),  32'h00);
      chk("mself.idle.mask", 32'(mask_b), 32'h40);
      step();
      chk("mself.clr.gnt",  32'(gnt_b),  32'h00);
      chk("mself.clr.mask", 32'(mask_b), 32'h00);
    end
    req_b = 8'h00;

    // 6. async reset mid-tenure
    req_a = 8'h10;
    step(); chk_a("arst.g", 8'h10, 3'd4, 8'h00);
    step();
    #2 rst = 1'b1;
    #1;
    chk_a("arst.now", 8'h00, 3'd0, 8'h00);
    chk("arst.no_req", 32'(nrq_a), 32'd1);
    @(negedge clk) rst = 1'b0;
    step(); chk_a("arst.regrant", 8'h10, 3'd4, 8'h00);
    req_a = 8'h00;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  // Invariant: valid tracks the one-hot grant on both instances.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv.a.valid", 32'(vld_a), 32'(|gnt_a));
      chk("inv.b.valid", 32'(vld_b), 32'(|gnt_b));
      chk("inv.a.onehot", 32'($countones(gnt_a) <= 1), 32'd1);
    end
  end
endmodule
